heart_hud_renderer: RTL and testbench

//  Draws the player's lives as a row of heart sprites in the top-left HUD, one heart per remaining life.

---
 rtl/heart_hud_renderer.sv | 146 ++++++++++++++
 tb/tb_heart_hud_renderer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/heart_hud_renderer.sv
// heart_hud_renderer
//   Draws the player's remaining lives as a row of 16x16 heart sprites in the top-left HUD.
//   It also tracks the lives count. A heart that has just been lost blinks for BLINK_FRAMES
//   frames before it disappears.
//
// Ports
//   Clk          in   pixel-domain clock
//   Reset        in   synchronous, active-high reset
//   DrawX/DrawY  in   current scan position
//   frame_start  in   one-cycle pulse per frame; paces the blink countdown
//   life_lost    in   one-cycle pulse: lose a life
//   life_gain    in   one-cycle pulse: gain a life, saturating at MAX_LIVES
//   game_restart in   one-cycle pulse: refill lives and leave game over
//   rom_addr     out  sprite ROM address {row, col}; combinational, 0 off-sprite
//   rom_data     in   sprite palette index, one cycle after rom_addr
//   heart_on     out  opaque heart pixel, two cycles after DrawX/DrawY
//   palette_idx  out  heart_palette index; 0 whenever heart_on is low
//   lives        out  remaining lives
//   game_over    out  high once the last life has finished blinking
module heart_hud_renderer #(
  parameter int unsigned MAX_LIVES    = 3,
  parameter int unsigned HUD_X0       = 8,
  parameter int unsigned HUD_Y0       = 8,
  parameter int unsigned PITCH        = 20,
  parameter int unsigned BLINK_FRAMES = 48
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       frame_start,
  input  logic       life_lost,
  input  logic       life_gain,
  input  logic       game_restart,
  output logic [7:0] rom_addr,
  input  logic [3:0] rom_data,
  output logic       heart_on,
  output logic [3:0] palette_idx,
  output logic [2:0] lives,
  output logic       game_over
);

  typedef enum logic [1:0] {StAlive, StBlink, StOver} state_e;

  state_e     state_q;
  logic [2:0] lives_q;
  logic [7:0] blink_cnt_q;
  logic       s1_q;
  logic       heart_on_q;
  logic [3:0] palette_idx_q;
  logic       game_over_q;

  logic        hit;
  logic [2:0]  slot;
  logic        visible;
  logic [10:0] dx;
  logic [10:0] dy;

  // Offsets are computed in 11 bits. A position left of or above a sprite wraps to a large
  // value, so a single "< 16" test covers both bounds.
  always_comb begin
    hit      = 1'b0;
    slot     = 3'd0;
    rom_addr = 8'd0;
    dx       = 11'd0;
    dy       = {1'b0, DrawY} - 11'(HUD_Y0);
    for (int unsigned k = 0; k < MAX_LIVES; k++) begin
      dx = {1'b0, DrawX} - 11'(HUD_X0 + k * PITCH);
      if (dy < 11'd16 && dx < 11'd16) begin
        hit      = 1'b1;
        slot     = 3'(k);
        rom_addr = {dy[3:0], dx[3:0]};
      end
    end
  end

  // The heart being lost sits at index lives_q. It shows only during the blink phase.
  always_comb begin
    visible = (slot < lives_q) ||
              (state_q == StBlink && slot == lives_q && blink_cnt_q[3]);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StAlive;
      lives_q       <= 3'(MAX_LIVES);
      blink_cnt_q   <= 8'd0;
      s1_q          <= 1'b0;
      heart_on_q    <= 1'b0;
      palette_idx_q <= 4'd0;
      game_over_q   <= 1'b0;
    end else begin
      s1_q          <= hit && visible;
      // Palette index 0 is the transparent key.
      heart_on_q    <= s1_q && (rom_data != 4'd0);
      palette_idx_q <= (s1_q && (rom_data != 4'd0)) ? rom_data : 4'd0;

      if (game_restart) begin
        state_q     <= StAlive;
        lives_q     <= 3'(MAX_LIVES);
        blink_cnt_q <= 8'd0;
        game_over_q <= 1'b0;
      end else begin
        unique case (state_q)
          StAlive: begin
            // A loss wins over a simultaneous gain.
            if (life_lost && lives_q != 3'd0) begin
              lives_q     <= lives_q - 3'd1;
              blink_cnt_q <= 8'(BLINK_FRAMES);
              state_q     <= StBlink;
            end else if (life_gain && lives_q < 3'(MAX_LIVES)) begin
              lives_q <= lives_q + 3'd1;
            end
          end
          StBlink: begin
            // Invulnerable here: life_lost and life_gain are ignored.
            if (frame_start) begin
              if (blink_cnt_q == 8'd1) begin
                blink_cnt_q <= 8'd0;
                if (lives_q != 3'd0) begin
                  state_q <= StAlive;
                end else begin
                  state_q     <= StOver;
                  game_over_q <= 1'b1;
                end
              end else begin
                blink_cnt_q <= blink_cnt_q - 8'd1;
              end
            end
          end
          StOver: begin
          end
          default: begin
            state_q <= StAlive;
          end
        endcase
      end
    end
  end

  assign heart_on    = heart_on_q;
  assign palette_idx = palette_idx_q;
  assign lives       = lives_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_heart_hud_renderer.sv
// Randomized bench for heart_hud_renderer. A behavioural model built from the sprite
// geometry and the lives/blink rules predicts rom_addr, heart_on, palette_idx, lives and
// game_over on every cycle.
module tb_heart_hud_renderer;

  localparam int MaxLives = 3;
  localparam int X0       = 8;
  localparam int Y0       = 8;
  localparam int Pitch    = 20;
  localparam int Frames   = 48;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_start;
  logic       life_lost;
  logic       life_gain;
  logic       game_restart;
  logic [7:0] rom_addr;
  logic [3:0] rom_data;
  logic       heart_on;
  logic [3:0] palette_idx;
  logic [2:0] lives;
  logic       game_over;

  logic [3:0] rom [256];

  int n_vec = 0;
  int n_err = 0;

  // Model state: m_mode 0 = alive, 1 = blinking, 2 = game over.
  int m_lives = MaxLives;
  int m_mode  = 0;
  int m_cnt   = 0;
  int m_px    = 0;  // visible-and-hit decision for the pixel from the previous cycle
  int m_rd    = 0;  // ROM value for that pixel
  int m_on    = 0;
  int m_pal   = 0;

  heart_hud_renderer #(
    .MAX_LIVES   (MaxLives),
    .HUD_X0      (X0),
    .HUD_Y0      (Y0),
    .PITCH       (Pitch),
    .BLINK_FRAMES(Frames)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .frame_start (frame_start),
    .life_lost   (life_lost),
    .life_gain   (life_gain),
    .game_restart(game_restart),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .heart_on    (heart_on),
    .palette_idx (palette_idx),
    .lives       (lives),
    .game_over   (game_over)
  );

  always #5 Clk = ~Clk;

  // Synchronous sprite ROM: data appears one cycle after the address.
  always @(posedge Clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void geom(input int x, input int y, output int hit, output int slot,
                               output int addr);
    hit  = 0;
    slot = 0;
    addr = 0;
    for (int k = 0; k < MaxLives; k++) begin
      if (y >= Y0 && y < Y0 + 16 && x >= X0 + k * Pitch && x < X0 + k * Pitch + 16) begin
        hit  = 1;
        slot = k;
        addr = (y - Y0) * 16 + (x - X0 - k * Pitch);
      end
    end
  endfunction

  // One clock cycle: inputs have already been driven just after the previous edge.
  task automatic tick();
    int hit, slot, addr, vis, px;
    #2;
    geom(int'(DrawX), int'(DrawY), hit, slot, addr);
    check("rom_addr", int'(rom_addr), addr);
    vis = (slot < m_lives) || (m_mode == 1 && slot == m_lives && ((m_cnt >> 3) & 1) == 1);
    px  = (hit != 0 && vis != 0 && !Reset) ? 1 : 0;
    @(posedge Clk);
    if (Reset) begin
      m_on  = 0;
      m_pal = 0;
    end else begin
      m_on  = (m_px != 0 && m_rd != 0) ? 1 : 0;
      m_pal = m_on ? m_rd : 0;
    end
    m_px = px;
    m_rd = int'(rom[addr]);
    if (Reset || game_restart) begin
      m_lives = MaxLives;
      m_mode  = 0;
      m_cnt   = 0;
    end else if (m_mode == 0) begin
      if (life_lost) begin
        m_lives = m_lives - 1;
        m_cnt   = Frames;
        m_mode  = 1;
      end else if (life_gain && m_lives < MaxLives) begin
        m_lives = m_lives + 1;
      end
    end else if (m_mode == 1 && frame_start) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_mode = (m_lives > 0) ? 0 : 2;
    end
    #1;
    check("heart_on", int'(heart_on), m_on);
    check("palette_idx", int'(palette_idx), m_pal);
    check("lives", int'(lives), m_lives);
    check("game_over", int'(game_over), (m_mode == 2) ? 1 : 0);
  endtask

  task automatic clear_pulses();
    frame_start  = 1'b0;
    life_lost    = 1'b0;
    life_gain    = 1'b0;
    game_restart = 1'b0;
    Reset        = 1'b0;
  endtask

  task automatic rnd_pos();
    DrawX = 10'($urandom_range(0, 79));
    DrawY = 10'($urandom_range(0, 31));
  endtask

  // Each frame is one frame_start pulse followed by two plain cycles of random scanning.
  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      frame_start = 1'b1;
      rnd_pos();
      tick();
      frame_start = 1'b0;
      for (int c = 0; c < 2; c++) begin
        rnd_pos();
        tick();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
    clear_pulses();
    Reset = 1'b1;
    DrawX = 10'd0;
    DrawY = 10'd0;
    for (int i = 0; i < 3; i++) tick();
    Reset = 1'b0;

    // Scan one HUD row across all three slots.
    DrawY = 10'd8;
    for (int x = 8; x <= 71; x++) begin
      DrawX = 10'(x);
      tick();
    end
    DrawX = 10'd0;
    tick();
    tick();

    // Lose every life, each loss followed by its full blink.
    for (int l = 0; l < 3; l++) begin
      life_lost = 1'b1;
      tick();
      life_lost = 1'b0;
      life_lost = 1'b1;  // ignored while blinking
      tick();
      life_lost = 1'b0;
      run_frames(Frames + 1);
    end
    life_gain = 1'b1;  // ignored in game over
    tick();
    clear_pulses();
    game_restart = 1'b1;
    tick();
    clear_pulses();

    // Loss and gain together, then gain at full health.
    life_lost = 1'b1;
    life_gain = 1'b1;
    tick();
    clear_pulses();
    run_frames(Frames);
    life_gain = 1'b1;
    tick();
    life_gain = 1'b1;
    tick();
    clear_pulses();

    // Restart in mid-blink with 20 frames left.
    life_lost = 1'b1;
    tick();
    clear_pulses();
    run_frames(Frames - 20);
    game_restart = 1'b1;
    tick();
    clear_pulses();
    run_frames(2);

    // Reset in mid-blink, mid-scan.
    life_lost = 1'b1;
    tick();
    clear_pulses();
    run_frames(30);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_pos();
      tick();
    end
    clear_pulses();

    // Random traffic.
    for (int i = 0; i < 20000; i++) begin
      rnd_pos();
      Reset        = ($urandom_range(0, 1999) == 0);
      game_restart = ($urandom_range(0, 599) == 0);
      life_lost    = ($urandom_range(0, 39) == 0);
      life_gain    = ($urandom_range(0, 39) == 0);
      frame_start  = ($urandom_range(0, 5) == 0);
      tick();
    end
    clear_pulses();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
